// File: rtl/ikaopll_pkg.sv
// Shared types and helpers for the OPLL wide-bus DAC accumulator and any later mixer.
package ikaopll_pkg;

    localparam int ACC_W  = 20;
    localparam int TERM_W = 14;
    localparam int PCM_W  = 16;

    typedef enum logic {SYNC, ACC} state_t;

    typedef struct packed {
        logic             clip;
        logic [PCM_W-1:0] val;
    } sat_t;

    localparam logic signed [ACC_W-1:0] PCM_MAX = 20'sd32767;
    localparam logic signed [ACC_W-1:0] PCM_MIN = -20'sd32768;

    function automatic sat_t sat16(input logic signed [ACC_W-1:0] x);
        sat_t r;
        r.clip = 1'b1;
        if (x > PCM_MAX) begin
            r.val = 16'h7FFF;
        end else if (x < PCM_MIN) begin
            r.val = 16'h8000;
        end else begin
            r.clip = 1'b0;
            r.val  = x[PCM_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ikaopll_signmag_scale.sv
// Sign+magnitude sample decode, MO/RO volume select and signed 9x5 scale (combinational).
module ikaopll_signmag_scale
    import ikaopll_pkg::*;
(
    input  logic                     en_mo,
    input  logic                     en_ro,
    input  logic                     sign,
    input  logic [7:0]               mag,
    input  logic [4:0]               movol,
    input  logic [4:0]               rovol,
    output logic signed [TERM_W-1:0] term
);

    logic signed [8:0]        val;
    logic [4:0]               vol;
    logic signed [TERM_W-1:0] prod;

    // -(mag+1) is exactly the bitwise inverse of the zero-extended magnitude
    assign val  = sign ? ~{1'b0, mag} : {1'b0, mag};
    assign vol  = en_mo ? movol : rovol;
    assign prod = $signed({{(TERM_W-9){val[8]}}, val}) * $signed({{(TERM_W-5){vol[4]}}, vol});
    assign term = (en_mo || en_ro) ? prod : '0;

endmodule

// File: rtl/ikaopll_sr.sv
// Clock-enabled shift register primitive; q is the bit shifted in LEN enables ago.
module ikaopll_sr #(
    parameter int LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic d,
    output logic q
);

    logic [LEN-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (cen) begin
            sr[0] <= d;
            for (int i = 1; i < LEN; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[LEN-1];

endmodule

// File: rtl/ikaopll_dac_acc.sv
// Frame accumulator turning per-slot operator samples into a saturated 16-bit PCM word.
//   state | meaning
//   SYNC  | waiting for the first frame boundary, terms discarded
//   ACC   | summing slot terms, emitting a sample at each boundary
module ikaopll_dac_acc
    import ikaopll_pkg::*;
#(
    parameter int CYC0_DLY  = 3,
    parameter int OUT_SHR   = 1,
    parameter int STRB_LEN  = 10,
    parameter int MAX_SLOTS = 24
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_00,
    input  logic        i_DAC_EN_MO,
    input  logic        i_DAC_EN_RO,
    input  logic        i_SIGN,
    input  logic [7:0]  i_MAG,
    input  logic [4:0]  i_MOVOL,
    input  logic [4:0]  i_ROVOL,
    output logic [15:0] o_ACC_SIGNED,
    output logic        o_ACC_SIGNED_STRB,
    output logic        o_CLIP,
    output logic        o_WDOG
);

    localparam int SLOT_W = $clog2(MAX_SLOTS);
    localparam int STRB_W = $clog2(STRB_LEN + 1);

    logic                     cen;
    logic                     fb;
    logic                     wdog_hit;
    logic                     emit;
    logic signed [TERM_W-1:0] term;
    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  acc, acc_nxt, acc_shr;
    logic [SLOT_W-1:0]        slot_cnt, slot_cnt_nxt;
    logic [STRB_W-1:0]        strb_cnt;
    state_t                   state, state_nxt;
    sat_t                     sat;

    assign cen = ~i_phi1_NCEN_n;

    ikaopll_sr #(.LEN(CYC0_DLY)) u_cyc0_dly (
        .clk (i_EMUCLK),
        .rst (i_RST),
        .cen (cen),
        .d   (i_CYCLE_00),
        .q   (fb)
    );

    ikaopll_signmag_scale u_scale (
        .en_mo (i_DAC_EN_MO),
        .en_ro (i_DAC_EN_RO),
        .sign  (i_SIGN),
        .mag   (i_MAG),
        .movol (i_MOVOL),
        .rovol (i_ROVOL),
        .term  (term)
    );

    assign term_ext = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
    assign acc_shr  = acc >>> OUT_SHR;
    assign sat      = sat16(acc_shr);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state <= SYNC;
        end else if (cen) begin
            state <= state_nxt;
        end
    end

    // The boundary slot's own term opens the new frame rather than closing the old one
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        slot_cnt_nxt = slot_cnt;
        emit         = 1'b0;
        wdog_hit     = 1'b0;
        case (state)
            SYNC: begin
                if (fb) begin
                    state_nxt    = ACC;
                    acc_nxt      = term_ext;
                    slot_cnt_nxt = '0;
                end
            end
            ACC: begin
                wdog_hit = !fb && (slot_cnt == SLOT_W'(MAX_SLOTS - 1));
                if (fb || wdog_hit) begin
                    emit         = 1'b1;
                    acc_nxt      = term_ext;
                    slot_cnt_nxt = '0;
                end else begin
                    acc_nxt      = acc + term_ext;
                    slot_cnt_nxt = slot_cnt + SLOT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            acc               <= '0;
            slot_cnt          <= '0;
            strb_cnt          <= '0;
            o_ACC_SIGNED      <= '0;
            o_ACC_SIGNED_STRB <= 1'b0;
            o_CLIP            <= 1'b0;
            o_WDOG            <= 1'b0;
        end else if (cen) begin
            acc               <= acc_nxt;
            slot_cnt          <= slot_cnt_nxt;
            o_ACC_SIGNED_STRB <= (strb_cnt != '0);
            if (emit) begin
                o_ACC_SIGNED <= sat.val;
                o_CLIP       <= sat.clip;
                o_WDOG       <= wdog_hit;
                strb_cnt     <= STRB_W'(STRB_LEN);
            end else if (strb_cnt != '0) begin
                strb_cnt <= strb_cnt - STRB_W'(1);
            end
        end
    end

endmodule
